// File: rtl/v_pkg.sv
// Shared vector-dispatch types and constants.
// Opcode map, dispatch FSM states and queue entry layout.
package v_pkg;

  localparam logic [6:0] OPC_OPV      = 7'h57;
  localparam logic [6:0] OPC_VLOAD    = 7'h07;
  localparam logic [6:0] OPC_VSTORE   = 7'h27;
  localparam logic [2:0] FUNCT3_OPCFG = 3'b111;

  typedef enum logic {
    DISP_IDLE,
    DISP_EXEC
  } dispatch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } disp_entry_t;

  function automatic logic is_vec_op(input logic [6:0] opc);
    return (opc == OPC_OPV) || (opc == OPC_VLOAD) ||
           (opc == OPC_VSTORE);
  endfunction

  function automatic logic is_cfg_op(input logic [31:0] instr);
    return (instr[6:0] == OPC_OPV) &&
           (instr[14:12] == FUNCT3_OPCFG);
  endfunction

endpackage

// File: rtl/carrd_sync_fifo.sv
// Small synchronous circular FIFO.
// Head data is combinational; clr empties it in one cycle.
module carrd_sync_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full && !clr;
  assign rd_en = pop && !empty && !clr;
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/carrd_dispatch.sv
// Vector instruction dispatch stage.
// Queues vector ops and holds one on the coprocessor until done.
module carrd_dispatch
  import v_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int TW      = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_rs1,
  input  logic [31:0]   in_rs2,
  input  logic          flush,
  input  logic          exec_done,
  output logic [31:0]   op_instr_base,
  output logic [31:0]   xreg_out1,
  output logic [31:0]   xreg_out2,
  output logic          busy,
  output logic [CW-1:0] q_count,
  output logic          err_illegal,
  output logic          err_timeout
);

  dispatch_state_t state, state_d;
  disp_entry_t     cur, cur_d, head, wentry;
  logic            cfg, cfg_d;
  logic [TW-1:0]   cnt, cnt_d;
  logic            tmo_d;
  logic            full, empty, pop;
  logic            accept, push, rel, to_hit;

  assign accept = in_valid && in_ready;
  assign push   = accept && is_vec_op(in_instr[6:0]) && !flush;
  assign wentry = '{instr: in_instr, rs1: in_rs1, rs2: in_rs2};
  assign to_hit = (cnt == TW'(TIMEOUT - 1));
  assign rel    = exec_done || cfg || to_hit;

  carrd_sync_fifo #(
    .WIDTH ($bits(disp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // Next state: load head when idle or on release, else hold.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    cfg_d   = cfg;
    cnt_d   = cnt;
    tmo_d   = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_d = DISP_IDLE;
      cur_d   = '0;
      cfg_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        DISP_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = DISP_EXEC;
            cur_d   = head;
            cfg_d   = is_cfg_op(head.instr);
            cnt_d   = '0;
          end
        end
        DISP_EXEC: begin
          if (rel) begin
            tmo_d = !exec_done && !cfg;
            if (!empty) begin
              pop   = 1'b1;
              cur_d = head;
              cfg_d = is_cfg_op(head.instr);
              cnt_d = '0;
            end else begin
              state_d = DISP_IDLE;
              cur_d   = '0;
              cfg_d   = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt + TW'(1);
          end
        end
        default: state_d = DISP_IDLE;
      endcase
    end
  end

  // Registered state, held operands and error pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= DISP_IDLE;
      cur         <= '0;
      cfg         <= 1'b0;
      cnt         <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cur         <= cur_d;
      cfg         <= cfg_d;
      cnt         <= cnt_d;
      err_illegal <= accept && !is_vec_op(in_instr[6:0]);
      err_timeout <= tmo_d;
    end
  end

  assign in_ready      = !full;
  assign busy          = (state == DISP_EXEC);
  assign op_instr_base = cur.instr;
  assign xreg_out1     = cur.rs1;
  assign xreg_out2     = cur.rs2;

endmodule

// File: tb/tb_carrd_dispatch.sv
// Scoreboard bench for carrd_dispatch.
// Issues are checked in order by a negedge monitor.
module tb_carrd_dispatch;
  import v_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instr = '0;
  logic [31:0]   in_rs1 = '0;
  logic [31:0]   in_rs2 = '0;
  logic          flush = 1'b0;
  logic          exec_done = 1'b0;
  logic          in_ready;
  logic [31:0]   op_instr_base;
  logic [31:0]   xreg_out1;
  logic [31:0]   xreg_out2;
  logic          busy;
  logic [CW-1:0] q_count;
  logic          err_illegal;
  logic          err_timeout;

  int          passed = 0;
  int          total = 0;
  disp_entry_t exp_q[$];
  disp_entry_t mon_e;
  logic        pb = 1'b0;
  logic [95:0] prev = '0;
  logic [95:0] cur_o;

  carrd_dispatch #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .flush         (flush),
    .exec_done     (exec_done),
    .op_instr_base (op_instr_base),
    .xreg_out1     (xreg_out1),
    .xreg_out2     (xreg_out2),
    .busy          (busy),
    .q_count       (q_count),
    .err_illegal   (err_illegal),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tb_vec(input logic [31:0] i);
    return i[6:0] == 7'h57 || i[6:0] == 7'h07 || i[6:0] == 7'h27;
  endfunction

  task automatic push(input logic [31:0] i,
                      input logic [31:0] r1,
                      input logic [31:0] r2);
    disp_entry_t e;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = i;
    in_rs1   = r1;
    in_rs2   = r2;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", in_ready, 1);
    tick();
    if (tb_vec(i)) begin
      e.instr = i;
      e.rs1   = r1;
      e.rs2   = r2;
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  assign cur_o = {op_instr_base, xreg_out1, xreg_out2};

  // Each newly issued instruction must match the queue head.
  always @(negedge clk) begin
    if (nrst && busy && (!pb || cur_o != prev)) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL issue_unexpected: got %0h expected none", cur_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_order", cur_o, mon_e);
      end
    end
    pb   <= busy && nrst;
    prev <= cur_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] vv [4];
    int n;
    // reset
    #3;
    check("rst_op", op_instr_base, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    check("rst_ready", in_ready, 1);
    check("rst_qcount", q_count, 0);
    check("rst_errs", {err_illegal, err_timeout}, 0);
    check("rst_x", {xreg_out1, xreg_out2}, 0);

    // 1: single vadd, two-cycle issue latency
    push(32'h02208057, 32'd5, 32'd7);
    check("t1_not_yet", busy, 0);
    check("t1_q1", q_count, 1);
    tick();
    check("t1_busy", busy, 1);
    check("t1_op", op_instr_base, 32'h02208057);
    check("t1_x", {xreg_out1, xreg_out2}, {32'd5, 32'd7});
    repeat (4) tick();
    check("t1_hold", op_instr_base, 32'h02208057);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t1_idle", busy, 0);
    check("t1_zero", cur_o, 0);

    // 2: fill the queue behind a stalled op
    vv[0] = 32'h02310057;
    vv[1] = 32'h02418057;
    vv[2] = 32'h02520057;
    vv[3] = 32'h02628057;
    push(32'h02108057, 32'h11, 32'h12);
    for (int i = 0; i < 4; i++) push(vv[i], 32'h20 + i, 32'h30 + i);
    check("t2_full", q_count, 4);
    check("t2_ready0", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("t2_nobubble", busy, 1);
      check("t2_next", op_instr_base, vv[i]);
      check("t2_count", q_count, 3 - i);
    end
    check("t2_ready1", in_ready, 1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t2_idle", busy, 0);

    // 3: vsetvli releases itself after one cycle
    push(32'h0D007057, 32'h40, 32'h41);
    push(32'h02A08057, 32'h50, 32'h51);
    check("t3_cfg", op_instr_base, 32'h0D007057);
    tick();
    check("t3_vadd", op_instr_base, 32'h02A08057);
    check("t3_busy", busy, 1);
    tick();
    check("t3_hold", op_instr_base, 32'h02A08057);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t3_idle", busy, 0);

    // 4: scalar op dropped
    push(32'h00B50533, 32'h1, 32'h2);
    check("t4_err", err_illegal, 1);
    check("t4_q0", q_count, 0);
    check("t4_ready", in_ready, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_err_pulse", err_illegal, 0);

    // 5: timeout release
    push(32'h02C08057, 32'h60, 32'h61);
    tick();
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("t5_cycles", n, TIMEOUT);
    check("t5_err", err_timeout, 1);
    check("t5_zero", cur_o, 0);
    tick();
    check("t5_pulse", err_timeout, 0);

    // 6: flush with a queue, then async reset mid-EXEC
    push(32'h02D08057, 32'h70, 32'h71);
    push(32'h02E08057, 32'h72, 32'h73);
    push(32'h02F08057, 32'h74, 32'h75);
    push(32'h03008057, 32'h76, 32'h77);
    check("t6_q3", q_count, 3);
    check("t6_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("t6_fl_busy", busy, 0);
    check("t6_fl_q", q_count, 0);
    check("t6_fl_zero", cur_o, 0);
    push(32'h03108057, 32'h80, 32'h81);
    tick();
    check("t6_busy2", busy, 1);
    #2;
    nrst = 1'b0;
    #1;
    exp_q.delete();
    check("t6_async_zero", cur_o, 0);
    check("t6_async_busy", busy, 0);
    tick();
    nrst = 1'b1;
    tick();
    check("t6_ready", in_ready, 1);
    check("t6_q0", q_count, 0);
    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/carrd_dispatch.md
Name: carrd_dispatch

Overview:
Instruction dispatch stage directly upstream of the vector coprocessor top.
- Accepts vector instructions plus their scalar operand values from the base processor over a valid/ready handshake, and buffers them in a small FIFO.
- Issues one instruction at a time, holding the instruction word and scalar operands stable on the coprocessor inputs until the execution-done pulse returns.
- Isolates the coprocessor's combinational decode from the base pipeline's timing.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
TIMEOUT, 1024, maximum cycles an instruction may stay in EXEC before a forced release.

Ports:
clk  in  1  clock; all state updates on the rising edge.
nrst  in  1  asynchronous active-low reset.
in_valid  in  1  base processor offers an instruction.
in_ready  out  1  dispatch can accept; equals !full.
in_instr  in  32  offered instruction word.
in_rs1  in  32  scalar rs1 value captured with the instruction.
in_rs2  in  32  scalar rs2 value captured with the instruction.
flush  in  1  synchronous discard of queue and in-flight instruction.
exec_done  in  1  one-cycle completion pulse from the coprocessor writeback/store path.
op_instr_base  out  32  instruction driven to the coprocessor; 0 when idle.
xreg_out1  out  32  held rs1 value.
xreg_out2  out  32  held rs2 value.
busy  out  1  high while in EXEC.
q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
err_illegal  out  1  one-cycle pulse: a non-vector instruction was offered and dropped.
err_timeout  out  1  one-cycle pulse: forced release after TIMEOUT.

Behaviour:
- Reset (nrst low, asynchronous):
  - FIFO emptied; q_count=0; state IDLE.
  - op_instr_base, xreg_out1 and xreg_out2 are 0.
  - busy, err_illegal and err_timeout are 0; in_ready=1 once released.
- Classification, opcode = in_instr[6:0]:
  - Vector opcodes are 7'h57 (OP-V), 7'h07 (vector load) and 7'h27 (vector store).
  - Config instruction: opcode 7'h57 with funct3 = in_instr[14:12] = 3'b111.
- Accept rule: a transfer occurs when in_valid && in_ready.
  - Vector instruction: {instr, rs1, rs2} is written to the FIFO tail.
  - Non-vector instruction: it is consumed but not stored, and err_illegal pulses in the next cycle.
- FIFO:
  - Circular buffer with pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - in_ready = (q_count != DEPTH); there is no bypass of a same-cycle pop.
  - No write can occur when full; no read can occur when empty.
- State machine (IDLE, EXEC), all outputs registered:
  - IDLE with FIFO non-empty: pop the head, load the outputs, go to EXEC. The instruction is visible on op_instr_base one cycle after the idle cycle.
  - IDLE with FIFO empty: stay; outputs held at 0.
  - EXEC release condition: exec_done=1, OR the instruction is a config instruction (released after exactly 1 cycle), OR the timeout counter reaches TIMEOUT-1.
  - On release with FIFO non-empty: pop the next entry back-to-back and stay in EXEC with new outputs. There is no bubble.
  - On release with FIFO empty: go to IDLE and zero the outputs.
  - exec_done is ignored in IDLE.
  - exec_done together with a timeout in the same cycle counts as a normal done; err_timeout stays 0.
- Timeout counter:
  - Cleared on every load into EXEC; increments each cycle in EXEC.
  - On timeout release, err_timeout pulses for 1 cycle.
- Flush (synchronous; highest priority after reset):
  - Next state is IDLE; FIFO emptied; outputs zeroed; counter cleared.
  - A push in the flush cycle is discarded.
- busy = (state == EXEC).
- q_count excludes the in-flight instruction.

Decomposition:
- Add to v_pkg:
  - OPC_OPV, OPC_VLOAD and OPC_VSTORE opcode constants.
  - FUNCT3_OPCFG constant.
  - dispatch_state_t enum {DISP_IDLE, DISP_EXEC}.
  - Packed struct disp_entry_t {instr, rs1, rs2} (96 bits).
- One sub-module: carrd_sync_fifo.
  - Parameterised width and depth; clk/nrst.
  - Ports: push, pop, wdata, rdata, full, empty and count.
  - Combinational rdata from the head.
- carrd_dispatch contains the classification logic, the state machine and the timeout counter.

Test Plan:
1. Reset then push vadd (32'h02208057, rs1=5, rs2=7), then pulse exec_done 6 cycles later:
   - op_instr_base=32'h02208057, xreg_out1=5, xreg_out2=7 and busy=1 from 2 cycles after the push.
   - Back to 0/idle the cycle after done.
2. Push 5 vector instructions while the first is stalled (DEPTH=4):
   - in_ready drops when q_count=4.
   - Each exec_done issues the next entry back-to-back in FIFO order, with no bubble.
3. Push vsetvli (32'h0D007057) followed by vadd, with no exec_done:
   - vsetvli occupies EXEC for exactly 1 cycle.
   - vadd appears on the next cycle.
4. Push scalar add (32'h00B50533):
   - No enqueue and q_count stays 0.
   - err_illegal=1 for one cycle; in_ready stays 1.
5. TIMEOUT=16, issue an instruction and never assert done:
   - err_timeout pulses on EXEC cycle 16.
   - Outputs return to 0.
6. Flush while in EXEC with q_count=3, plus nrst asserted mid-EXEC:
   - Next cycle busy=0, q_count=0, outputs 0.
   - Reset clears the outputs asynchronously, before the next clock edge.
